am9513_csr_target: RTL and testbench

CSR responder for the Am9513 accelerator's configuration register bank: the target end of the csr request/response handshake that the system init sequencer and debug masters drive. It accepts one request at a time, applies privilege and address checks, updates or reads the register file, and returns a single response after a programmable latency. Its configuration outputs feed the Am9513 datapath and CAI completion logic directly.

---
 rtl/am9513_pkg.sv | 28 ++
 rtl/carbon_arch_pkg.sv | 12 +
 rtl/am9513_csr_regfile.sv | 64 ++++++
 rtl/am9513_csr_target.sv | 162 ++++++++++++++++
 tb/tb_am9513_csr_target.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/am9513_pkg.sv
// Am9513 CSR bank shared definitions: MODE limit, CTRL/STATUS bit positions, FSM states.
package am9513_pkg;

  localparam logic [7:0] MODE_MAX_DEFAULT = 8'h03;

  localparam int CTRL_ENABLE_BIT     = 0;
  localparam int CTRL_SOFT_RESET_BIT = 1;
  localparam int STATUS_ENABLE_BIT   = 0;
  localparam int STATUS_BUSY_BIT     = 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } csr_state_e;

  function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                             input logic [31:0] newVal,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    merged = oldVal;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) merged[8*b +: 8] = newVal[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/carbon_arch_pkg.sv
// Carbon SoC architectural constants: CSR address map for the Am9513 register bank.
package carbon_arch_pkg;

  localparam logic [31:0] CARBON_CSR_AM9513_CTRL           = 32'h0000_4000;
  localparam logic [31:0] CARBON_CSR_AM9513_STATUS         = 32'h0000_4004;
  localparam logic [31:0] CARBON_CSR_AM9513_MODE           = 32'h0000_4008;
  localparam logic [31:0] CARBON_CSR_AM9513_COMP_BASE_LO   = 32'h0000_400C;
  localparam logic [31:0] CARBON_CSR_AM9513_COMP_BASE_HI   = 32'h0000_4010;
  localparam logic [31:0] CARBON_CSR_AM9513_COMP_RING_MASK = 32'h0000_4014;
  localparam logic [31:0] CARBON_CSR_AM9513_CAI_IRQ_ENABLE = 32'h0000_4018;

endpackage

// File: rtl/am9513_csr_regfile.sv
// Am9513 CSR storage: per-register write enables with byte-lane merge and a bulk soft clear.
module am9513_csr_regfile
  import am9513_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  input  logic        i_we_ctrl,
  input  logic        i_we_mode,
  input  logic        i_we_comp_lo,
  input  logic        i_we_comp_hi,
  input  logic        i_we_ring_mask,
  input  logic        i_we_irq_enable,
  input  logic        i_soft_clear,
  output logic        o_enable,
  output logic [7:0]  o_mode,
  output logic [31:0] o_comp_lo,
  output logic [31:0] o_comp_hi,
  output logic [31:0] o_ring_mask,
  output logic [31:0] o_irq_enable
);

  logic        r_enable;
  logic [7:0]  r_mode;
  logic [31:0] r_comp_lo;
  logic [31:0] r_comp_hi;
  logic [31:0] r_ring_mask;
  logic [31:0] r_irq_enable;

  // Soft clear wins over the write that requested it, so CTRL[0] ends up 0 whatever wdata[0] was.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enable     <= 1'b0;
      r_mode       <= '0;
      r_comp_lo    <= '0;
      r_comp_hi    <= '0;
      r_ring_mask  <= '0;
      r_irq_enable <= '0;
    end else if (i_soft_clear) begin
      r_enable     <= 1'b0;
      r_mode       <= '0;
      r_comp_lo    <= '0;
      r_comp_hi    <= '0;
      r_ring_mask  <= '0;
      r_irq_enable <= '0;
    end else begin
      if (i_we_ctrl && i_wstrb[0]) r_enable <= i_wdata[CTRL_ENABLE_BIT];
      if (i_we_mode && i_wstrb[0]) r_mode <= i_wdata[7:0];
      if (i_we_comp_lo)    r_comp_lo    <= mergeBytes(r_comp_lo, i_wdata, i_wstrb);
      if (i_we_comp_hi)    r_comp_hi    <= mergeBytes(r_comp_hi, i_wdata, i_wstrb);
      if (i_we_ring_mask)  r_ring_mask  <= mergeBytes(r_ring_mask, i_wdata, i_wstrb);
      if (i_we_irq_enable) r_irq_enable <= mergeBytes(r_irq_enable, i_wdata, i_wstrb);
    end
  end

  assign o_enable     = r_enable;
  assign o_mode       = r_mode;
  assign o_comp_lo    = r_comp_lo;
  assign o_comp_hi    = r_comp_hi;
  assign o_ring_mask  = r_ring_mask;
  assign o_irq_enable = r_irq_enable;

endmodule

// File: rtl/am9513_csr_target.sv
// Am9513 CSR target: accepts one request at a time, checks privilege/address/legality,
// updates the register file and returns a single response after RESP_LATENCY wait cycles.
module am9513_csr_target
  import am9513_pkg::*;
  import carbon_arch_pkg::*;
#(
  parameter int unsigned RESP_LATENCY = 1,
  parameter logic [1:0]  MIN_PRIV     = 2'd1,
  parameter logic [7:0]  MODE_MAX     = MODE_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_wstrb,
  input  logic [1:0]  i_req_priv,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_fault,
  input  logic        i_core_busy,
  output logic        o_cfg_enable,
  output logic [7:0]  o_cfg_mode,
  output logic [63:0] o_cfg_comp_base,
  output logic [31:0] o_cfg_ring_mask,
  output logic [31:0] o_cfg_irq_enable,
  output logic        o_cfg_soft_reset
);

  localparam logic [3:0] WAIT_LOAD = (RESP_LATENCY > 0) ? 4'(RESP_LATENCY - 1) : 4'd0;

  csr_state_e  r_state, w_state_next;
  logic [3:0]  r_wait_cnt, w_wait_cnt_next;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_fault;
  logic        r_soft_reset;

  logic        w_hit_ctrl, w_hit_status, w_hit_mode, w_hit_lo, w_hit_hi, w_hit_mask, w_hit_irq;
  logic        w_mapped, w_fault, w_accept, w_wr_ok, w_soft_clear;
  logic [31:0] w_rdata;
  logic        w_enable;
  logic [7:0]  w_mode;
  logic [31:0] w_comp_lo, w_comp_hi, w_ring_mask, w_irq_enable;

  assign w_hit_ctrl   = (i_req_addr == CARBON_CSR_AM9513_CTRL);
  assign w_hit_status = (i_req_addr == CARBON_CSR_AM9513_STATUS);
  assign w_hit_mode   = (i_req_addr == CARBON_CSR_AM9513_MODE);
  assign w_hit_lo     = (i_req_addr == CARBON_CSR_AM9513_COMP_BASE_LO);
  assign w_hit_hi     = (i_req_addr == CARBON_CSR_AM9513_COMP_BASE_HI);
  assign w_hit_mask   = (i_req_addr == CARBON_CSR_AM9513_COMP_RING_MASK);
  assign w_hit_irq    = (i_req_addr == CARBON_CSR_AM9513_CAI_IRQ_ENABLE);
  assign w_mapped     = w_hit_ctrl | w_hit_status | w_hit_mode | w_hit_lo |
                        w_hit_hi | w_hit_mask | w_hit_irq;

  // Checks in priority order; any fault suppresses every state change.
  always_comb begin
    w_fault = 1'b0;
    if (i_req_priv < MIN_PRIV)                 w_fault = 1'b1;
    else if (!w_mapped)                        w_fault = 1'b1;
    else if (i_req_write && w_hit_status)      w_fault = 1'b1;
    else if (i_req_write && w_hit_mode && i_req_wstrb[0] &&
             (i_req_wdata[7:0] > MODE_MAX))    w_fault = 1'b1;
  end

  always_comb begin
    w_rdata = '0;
    if (w_hit_ctrl)   w_rdata[CTRL_ENABLE_BIT] = w_enable;
    if (w_hit_status) begin
      w_rdata[STATUS_ENABLE_BIT] = w_enable;
      w_rdata[STATUS_BUSY_BIT]   = i_core_busy;
    end
    if (w_hit_mode)   w_rdata[7:0] = w_mode;
    if (w_hit_lo)     w_rdata = w_comp_lo;
    if (w_hit_hi)     w_rdata = w_comp_hi;
    if (w_hit_mask)   w_rdata = w_ring_mask;
    if (w_hit_irq)    w_rdata = w_irq_enable;
  end

  assign w_accept     = (r_state == IDLE) && i_req_valid;
  assign w_wr_ok      = w_accept && i_req_write && !w_fault;
  assign w_soft_clear = w_wr_ok && w_hit_ctrl && i_req_wstrb[0] &&
                        i_req_wdata[CTRL_SOFT_RESET_BIT];

  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    case (r_state)
      IDLE: begin
        if (i_req_valid) begin
          if (RESP_LATENCY > 0) begin
            w_state_next    = WAIT;
            w_wait_cnt_next = WAIT_LOAD;
          end else begin
            w_state_next = RESP;
          end
        end
      end
      WAIT: begin
        if (r_wait_cnt == 4'd0) w_state_next = RESP;
        else                    w_wait_cnt_next = r_wait_cnt - 4'd1;
      end
      RESP: begin
        if (i_rsp_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Response payload is frozen at the accept edge and held until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_wait_cnt   <= '0;
      r_rsp_rdata  <= '0;
      r_rsp_fault  <= 1'b0;
      r_soft_reset <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_wait_cnt   <= w_wait_cnt_next;
      r_soft_reset <= w_soft_clear;
      if (w_accept) begin
        r_rsp_rdata <= (i_req_write || w_fault) ? 32'd0 : w_rdata;
        r_rsp_fault <= w_fault;
      end
    end
  end

  am9513_csr_regfile u_regfile (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_wdata         (i_req_wdata),
    .i_wstrb         (i_req_wstrb),
    .i_we_ctrl       (w_wr_ok && w_hit_ctrl),
    .i_we_mode       (w_wr_ok && w_hit_mode),
    .i_we_comp_lo    (w_wr_ok && w_hit_lo),
    .i_we_comp_hi    (w_wr_ok && w_hit_hi),
    .i_we_ring_mask  (w_wr_ok && w_hit_mask),
    .i_we_irq_enable (w_wr_ok && w_hit_irq),
    .i_soft_clear    (w_soft_clear),
    .o_enable        (w_enable),
    .o_mode          (w_mode),
    .o_comp_lo       (w_comp_lo),
    .o_comp_hi       (w_comp_hi),
    .o_ring_mask     (w_ring_mask),
    .o_irq_enable    (w_irq_enable)
  );

  assign o_req_ready      = (r_state == IDLE);
  assign o_rsp_valid      = (r_state == RESP);
  assign o_rsp_rdata      = r_rsp_rdata;
  assign o_rsp_fault      = r_rsp_fault;
  assign o_cfg_enable     = w_enable;
  assign o_cfg_mode       = w_mode;
  assign o_cfg_comp_base  = {w_comp_hi, w_comp_lo};
  assign o_cfg_ring_mask  = w_ring_mask;
  assign o_cfg_irq_enable = w_irq_enable;
  assign o_cfg_soft_reset = r_soft_reset;

endmodule

// File: tb/tb_am9513_csr_target.sv
// Testbench for am9513_csr_target: scoreboarded CSR accesses, fault cases, backpressure and resets.
module tb_am9513_csr_target;
  import carbon_arch_pkg::*;

  localparam int unsigned LATENCY = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_write = 1'b0;
  logic [31:0] i_req_addr = '0;
  logic [31:0] i_req_wdata = '0;
  logic [3:0]  i_req_wstrb = '0;
  logic [1:0]  i_req_priv = '0;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b0;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_fault;
  logic        i_core_busy = 1'b0;
  logic        o_cfg_enable;
  logic [7:0]  o_cfg_mode;
  logic [63:0] o_cfg_comp_base;
  logic [31:0] o_cfg_ring_mask;
  logic [31:0] o_cfg_irq_enable;
  logic        o_cfg_soft_reset;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        fault;
  } expect_t;

  expect_t sbQueue[$];
  int checkCount = 0;
  int passCount  = 0;

  am9513_csr_target #(
    .RESP_LATENCY (LATENCY),
    .MIN_PRIV     (2'd1),
    .MODE_MAX     (8'h03)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_req_valid      (i_req_valid),
    .o_req_ready      (o_req_ready),
    .i_req_write      (i_req_write),
    .i_req_addr       (i_req_addr),
    .i_req_wdata      (i_req_wdata),
    .i_req_wstrb      (i_req_wstrb),
    .i_req_priv       (i_req_priv),
    .o_rsp_valid      (o_rsp_valid),
    .i_rsp_ready      (i_rsp_ready),
    .o_rsp_rdata      (o_rsp_rdata),
    .o_rsp_fault      (o_rsp_fault),
    .i_core_busy      (i_core_busy),
    .o_cfg_enable     (o_cfg_enable),
    .o_cfg_mode       (o_cfg_mode),
    .o_cfg_comp_base  (o_cfg_comp_base),
    .o_cfg_ring_mask  (o_cfg_ring_mask),
    .o_cfg_irq_enable (o_cfg_irq_enable),
    .o_cfg_soft_reset (o_cfg_soft_reset)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Drives one request, pushes its expected response, and returns at the negedge after accept.
  task automatic applyStimulus(input string tag, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] wstrb,
                               input logic [1:0] priv, input logic [31:0] expRdata,
                               input logic expFault);
    expect_t e;
    @(negedge clk);
    checkOutput({tag, " req_ready"}, 64'(o_req_ready), 64'd1);
    i_req_valid = 1'b1;
    i_req_write = wr;
    i_req_addr  = addr;
    i_req_wdata = wdata;
    i_req_wstrb = wstrb;
    i_req_priv  = priv;
    e.tag   = tag;
    e.rdata = expRdata;
    e.fault = expFault;
    sbQueue.push_back(e);
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
    i_req_write = 1'b0;
    @(negedge clk);
  endtask

  // elapsed = negedges already seen since the accept edge; holdCycles > 0 exercises backpressure.
  task automatic collectResponse(input int elapsed, input int holdCycles);
    int          waited;
    expect_t     e;
    logic [31:0] expRdata;
    waited   = elapsed;
    expRdata = '0;
    while (!o_rsp_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!o_rsp_valid) begin
      checkOutput("rsp timeout", 64'd0, 64'd1);
      sbQueue.delete();
      return;
    end
    if (sbQueue.size() == 0) begin
      checkOutput("unexpected rsp", 64'd1, 64'd0);
    end else begin
      e = sbQueue.pop_front();
      expRdata = e.rdata;
      checkOutput({e.tag, " latency"}, 64'(waited), 64'(LATENCY + 1));
      checkOutput({e.tag, " rdata"}, 64'(o_rsp_rdata), 64'(e.rdata));
      checkOutput({e.tag, " fault"}, 64'(o_rsp_fault), 64'(e.fault));
    end
    for (int i = 0; i < holdCycles; i++) begin
      if (i == 0) begin
        i_req_valid = 1'b1;
        i_req_write = 1'b1;
        i_req_addr  = CARBON_CSR_AM9513_CTRL;
        i_req_wdata = 32'h0;
        i_req_wstrb = 4'hF;
        i_req_priv  = 2'd3;
      end
      @(negedge clk);
      checkOutput("hold rsp_valid", 64'(o_rsp_valid), 64'd1);
      checkOutput("hold rdata", 64'(o_rsp_rdata), 64'(expRdata));
      checkOutput("hold req_ready", 64'(o_req_ready), 64'd0);
    end
    i_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    i_rsp_ready = 1'b0;
    i_req_valid = 1'b0;
    i_req_write = 1'b0;
    @(negedge clk);
    checkOutput("post-rsp req_ready", 64'(o_req_ready), 64'd1);
    checkOutput("post-rsp rsp_valid", 64'(o_rsp_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic sawValid;

    #2;
    checkOutput("reset req_ready", 64'(o_req_ready), 64'd1);
    checkOutput("reset rsp_valid", 64'(o_rsp_valid), 64'd0);
    checkOutput("reset rsp_rdata", 64'(o_rsp_rdata), 64'd0);
    checkOutput("reset rsp_fault", 64'(o_rsp_fault), 64'd0);
    checkOutput("reset cfg_enable", 64'(o_cfg_enable), 64'd0);
    checkOutput("reset cfg_mode", 64'(o_cfg_mode), 64'd0);
    checkOutput("reset comp_base", o_cfg_comp_base, 64'd0);
    checkOutput("reset ring_mask", 64'(o_cfg_ring_mask), 64'd0);
    checkOutput("reset irq_enable", 64'(o_cfg_irq_enable), 64'd0);
    checkOutput("reset soft_reset", 64'(o_cfg_soft_reset), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("wr ctrl", 1'b1, CARBON_CSR_AM9513_CTRL, 32'h1, 4'hF, 2'd1, 32'h0, 1'b0);
    checkOutput("ctrl cfg_enable", 64'(o_cfg_enable), 64'd1);
    collectResponse(1, 0);

    applyStimulus("rd ctrl", 1'b0, CARBON_CSR_AM9513_CTRL, 32'h0, 4'h0, 2'd1, 32'h1, 1'b0);
    collectResponse(1, 0);

    i_core_busy = 1'b1;
    applyStimulus("rd status", 1'b0, CARBON_CSR_AM9513_STATUS, 32'h0, 4'h0, 2'd2, 32'h3, 1'b0);
    collectResponse(1, 0);
    i_core_busy = 1'b0;

    applyStimulus("wr mode 7", 1'b1, CARBON_CSR_AM9513_MODE, 32'h7, 4'hF, 2'd1, 32'h0, 1'b1);
    checkOutput("mode 7 rejected", 64'(o_cfg_mode), 64'd0);
    collectResponse(1, 0);

    applyStimulus("wr mode 3", 1'b1, CARBON_CSR_AM9513_MODE, 32'h3, 4'hF, 2'd1, 32'h0, 1'b0);
    checkOutput("mode 3 max", 64'(o_cfg_mode), 64'h3);
    collectResponse(1, 0);

    applyStimulus("wr mode 2", 1'b1, CARBON_CSR_AM9513_MODE, 32'h2, 4'hF, 2'd1, 32'h0, 1'b0);
    checkOutput("mode 2", 64'(o_cfg_mode), 64'h2);
    collectResponse(1, 0);

    applyStimulus("wr lo full", 1'b1, CARBON_CSR_AM9513_COMP_BASE_LO, 32'h1122_3344, 4'hF, 2'd1, 32'h0, 1'b0);
    collectResponse(1, 0);
    applyStimulus("wr lo strb", 1'b1, CARBON_CSR_AM9513_COMP_BASE_LO, 32'hAABB_CCDD, 4'b0101, 2'd1, 32'h0, 1'b0);
    checkOutput("lo merged cfg", o_cfg_comp_base, 64'h0000_0000_11BB_33DD);
    collectResponse(1, 0);
    applyStimulus("rd lo", 1'b0, CARBON_CSR_AM9513_COMP_BASE_LO, 32'h0, 4'h0, 2'd1, 32'h11BB_33DD, 1'b0);
    collectResponse(1, 0);

    applyStimulus("wr hi strb0", 1'b1, CARBON_CSR_AM9513_COMP_BASE_HI, 32'hFFFF_FFFF, 4'h0, 2'd1, 32'h0, 1'b0);
    checkOutput("hi strb0 unchanged", o_cfg_comp_base, 64'h0000_0000_11BB_33DD);
    collectResponse(1, 0);

    applyStimulus("wr irq", 1'b1, CARBON_CSR_AM9513_CAI_IRQ_ENABLE, 32'hFFFF_0000, 4'hF, 2'd1, 32'h0, 1'b0);
    collectResponse(1, 0);
    applyStimulus("wr irq priv0", 1'b1, CARBON_CSR_AM9513_CAI_IRQ_ENABLE, 32'h1234_5678, 4'hF, 2'd0, 32'h0, 1'b1);
    checkOutput("irq priv0 unchanged", 64'(o_cfg_irq_enable), 64'hFFFF_0000);
    collectResponse(1, 0);
    applyStimulus("rd irq priv0", 1'b0, CARBON_CSR_AM9513_CAI_IRQ_ENABLE, 32'h0, 4'h0, 2'd0, 32'h0, 1'b1);
    collectResponse(1, 0);

    applyStimulus("rd unmapped", 1'b0, 32'h0000_4FFC, 32'h0, 4'h0, 2'd3, 32'h0, 1'b1);
    collectResponse(1, 0);

    applyStimulus("wr status", 1'b1, CARBON_CSR_AM9513_STATUS, 32'h0, 4'hF, 2'd3, 32'h0, 1'b1);
    checkOutput("status wr enable kept", 64'(o_cfg_enable), 64'd1);
    collectResponse(1, 0);

    applyStimulus("rd mode hold", 1'b0, CARBON_CSR_AM9513_MODE, 32'h0, 4'h0, 2'd1, 32'h2, 1'b0);
    collectResponse(1, 5);
    checkOutput("blocked req ignored", 64'(o_cfg_enable), 64'd1);

    applyStimulus("wr hi", 1'b1, CARBON_CSR_AM9513_COMP_BASE_HI, 32'hCAFE_0001, 4'hF, 2'd1, 32'h0, 1'b0);
    collectResponse(1, 0);
    applyStimulus("wr ring", 1'b1, CARBON_CSR_AM9513_COMP_RING_MASK, 32'h0000_FFFF, 4'hF, 2'd1, 32'h0, 1'b0);
    checkOutput("ring cfg", 64'(o_cfg_ring_mask), 64'h0000_FFFF);
    collectResponse(1, 0);

    applyStimulus("wr soft", 1'b1, CARBON_CSR_AM9513_CTRL, 32'h3, 4'hF, 2'd1, 32'h0, 1'b0);
    checkOutput("soft pulse", 64'(o_cfg_soft_reset), 64'd1);
    checkOutput("soft enable", 64'(o_cfg_enable), 64'd0);
    checkOutput("soft mode", 64'(o_cfg_mode), 64'd0);
    checkOutput("soft comp_base", o_cfg_comp_base, 64'd0);
    checkOutput("soft ring", 64'(o_cfg_ring_mask), 64'd0);
    checkOutput("soft irq", 64'(o_cfg_irq_enable), 64'd0);
    @(negedge clk);
    checkOutput("soft pulse end", 64'(o_cfg_soft_reset), 64'd0);
    collectResponse(2, 0);
    applyStimulus("rd mode soft", 1'b0, CARBON_CSR_AM9513_MODE, 32'h0, 4'h0, 2'd1, 32'h0, 1'b0);
    collectResponse(1, 0);
    applyStimulus("rd ctrl soft", 1'b0, CARBON_CSR_AM9513_CTRL, 32'h0, 4'h0, 2'd1, 32'h0, 1'b0);
    collectResponse(1, 0);

    applyStimulus("wr ctrl again", 1'b1, CARBON_CSR_AM9513_CTRL, 32'h1, 4'hF, 2'd1, 32'h0, 1'b0);
    collectResponse(1, 0);
    applyStimulus("wr irq midrst", 1'b1, CARBON_CSR_AM9513_CAI_IRQ_ENABLE, 32'hA5A5_0000, 4'hF, 2'd1, 32'h0, 1'b0);
    checkOutput("midrst irq before", 64'(o_cfg_irq_enable), 64'hA5A5_0000);
    checkOutput("midrst in wait", 64'(o_rsp_valid), 64'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst req_ready", 64'(o_req_ready), 64'd1);
    checkOutput("midrst rsp_valid", 64'(o_rsp_valid), 64'd0);
    checkOutput("midrst rdata", 64'(o_rsp_rdata), 64'd0);
    checkOutput("midrst fault", 64'(o_rsp_fault), 64'd0);
    checkOutput("midrst enable", 64'(o_cfg_enable), 64'd0);
    checkOutput("midrst irq", 64'(o_cfg_irq_enable), 64'd0);
    sbQueue.delete();
    @(negedge clk);
    rst_n = 1'b1;
    sawValid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (o_rsp_valid) sawValid = 1'b1;
    end
    checkOutput("midrst no rsp", 64'(sawValid), 64'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
